// File: rtl/execute_muldiv_unit_pkg.sv
// RV32M opcode constants and shared state encoding for the M-extension unit.
package RV32M_Inst_Pkg;

  localparam logic [6:0] RV32M_FUNCT7 = 7'b0000001;

  localparam logic [2:0] RV32M_MUL    = 3'b000;
  localparam logic [2:0] RV32M_MULH   = 3'b001;
  localparam logic [2:0] RV32M_MULHSU = 3'b010;
  localparam logic [2:0] RV32M_MULHU  = 3'b011;
  localparam logic [2:0] RV32M_DIV    = 3'b100;
  localparam logic [2:0] RV32M_DIVU   = 3'b101;
  localparam logic [2:0] RV32M_REM    = 3'b110;
  localparam logic [2:0] RV32M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE     = 2'd0,
    MD_MUL_ITER = 2'd1,
    MD_DIV_ITER = 2'd2,
    MD_FINISH   = 2'd3
  } muldiv_state_t;

  // rs1 is treated as signed for these ops (MUL low half is sign-agnostic)
  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == RV32M_MULH) || (f3 == RV32M_MULHSU) ||
           (f3 == RV32M_DIV)  || (f3 == RV32M_REM);
  endfunction

  // rs2 is treated as signed for these ops
  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == RV32M_MULH) || (f3 == RV32M_DIV) || (f3 == RV32M_REM);
  endfunction

endpackage

// File: rtl/execute_muldiv_unit_div_step.sv
// Combinational restoring-division step: resolves DIV_BITS_PER_CYCLE
// quotient bits. The dividend is shifted out of quo_i MSB-first while
// quotient bits are shifted in at the LSB.
module muldiv_div_step #(
  parameter int XLEN               = 32,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN-1:0] r, q;
  logic [XLEN:0]   tmp, diff;

  // Chain of trial subtractions; a borrow (diff MSB) restores the remainder.
  // The partial remainder stays below the divisor, so XLEN+1 bits suffice.
  always_comb begin
    r    = rem_i;
    q    = quo_i;
    tmp  = '0;
    diff = '0;
    for (int k = 0; k < DIV_BITS_PER_CYCLE; k++) begin
      tmp  = {r, q[XLEN-1]};
      diff = tmp - {1'b0, divisor_i};
      if (!diff[XLEN]) r = diff[XLEN-1:0];
      else             r = tmp[XLEN-1:0];
      q = {q[XLEN-2:0], ~diff[XLEN]};
    end
    rem_o = r;
    quo_o = q;
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit. Operates on operand magnitudes
// and applies sign correction in FINISH. Divide-by-zero and signed overflow
// bypass the iterations with precomputed raw results.
module execute_muldiv_unit
  import RV32M_Inst_Pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int MUL_ITERATIVE      = 0,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int DIV_ITERS = XLEN / DIV_BITS_PER_CYCLE;
  localparam int CNT_W     = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg1_q, neg1_d, neg2_q, neg2_d;
  logic              special_q, special_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // MUL: {partial product, multiplier}; DIV: {remainder, quotient/dividend}
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  // Request decode
  logic            is_div_in, sgn1_in, sgn2_in, neg1_in, neg2_in, div0_in, ovf_in;
  logic [XLEN-1:0] mag1_in, mag2_in;

  assign is_div_in = funct3[2];
  assign sgn1_in   = rs1_signed(funct3);
  assign sgn2_in   = rs2_signed(funct3);
  assign neg1_in   = sgn1_in & operand1[XLEN-1];
  assign neg2_in   = sgn2_in & operand2[XLEN-1];
  assign mag1_in   = neg1_in ? -operand1 : operand1;
  assign mag2_in   = neg2_in ? -operand2 : operand2;
  assign div0_in   = (operand2 == '0);
  assign ovf_in    = sgn1_in & sgn2_in & (operand1 == MOST_NEG) & (operand2 == '1);

  // Radix-2 shift-add step: conditionally add multiplicand, shift right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Division step
  logic [XLEN-1:0] div_rem, div_quo;
  muldiv_div_step #(
    .XLEN               (XLEN),
    .DIV_BITS_PER_CYCLE (DIV_BITS_PER_CYCLE)
  ) u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .quo_i     (acc_q[XLEN-1:0]),
    .divisor_i (b_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  // Unsigned product of magnitudes
  logic [2*XLEN-1:0] prod_raw;
  generate
    if (MUL_ITERATIVE != 0) begin : g_mul_iter
      assign prod_raw = acc_q;
    end else begin : g_mul_fast
      assign prod_raw = {{XLEN{1'b0}}, acc_q[XLEN-1:0]} * {{XLEN{1'b0}}, b_q};
    end
  endgenerate

  // Sign correction and half/quotient/remainder selection
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin_res;

  assign prod_s = (neg1_q ^ neg2_q) ? -prod_raw : prod_raw;
  assign quo_s  = (special_q || !(neg1_q ^ neg2_q)) ? acc_q[XLEN-1:0] : -acc_q[XLEN-1:0];
  assign rem_s  = (special_q || !neg1_q) ? acc_q[2*XLEN-1:XLEN] : -acc_q[2*XLEN-1:XLEN];

  // Final result mux keyed by the latched funct3
  always_comb begin
    fin_res = prod_s[XLEN-1:0];
    case (op_q)
      RV32M_MULH, RV32M_MULHSU, RV32M_MULHU: fin_res = prod_s[2*XLEN-1:XLEN];
      RV32M_DIV,  RV32M_DIVU:                fin_res = quo_s;
      RV32M_REM,  RV32M_REMU:                fin_res = rem_s;
      default:                               fin_res = prod_s[XLEN-1:0];
    endcase
  end

  // Next-state logic; flush outranks every non-idle state including FINISH
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    result_d  = result_q;
    done_d    = 1'b0;
    if (state_q != MD_IDLE && flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start && !flush) begin
            op_d      = funct3;
            neg1_d    = neg1_in;
            neg2_d    = neg2_in;
            special_d = 1'b0;
            b_d       = mag2_in;
            acc_d     = {{XLEN{1'b0}}, mag1_in};
            if (!is_div_in) begin
              if (MUL_ITERATIVE != 0) begin
                cnt_d   = MUL_LAST;
                state_d = MD_MUL_ITER;
              end else begin
                state_d = MD_FINISH;
              end
            end else if (div0_in) begin
              // quotient all ones, remainder = raw dividend
              special_d = 1'b1;
              acc_d     = {operand1, {XLEN{1'b1}}};
              state_d   = MD_FINISH;
            end else if (ovf_in) begin
              // quotient = raw dividend, remainder 0
              special_d = 1'b1;
              acc_d     = {{XLEN{1'b0}}, operand1};
              state_d   = MD_FINISH;
            end else begin
              cnt_d   = DIV_LAST;
              state_d = MD_DIV_ITER;
            end
          end
        end
        MD_MUL_ITER: begin
          acc_d = mul_step;
          if (cnt_q == '0) state_d = MD_FINISH;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        MD_DIV_ITER: begin
          acc_d = {div_rem, div_quo};
          if (cnt_q == '0) state_d = MD_FINISH;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        MD_FINISH: begin
          result_d = fin_res;
          done_d   = 1'b1;
          state_d  = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      op_q      <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign ready  = (state_q == MD_IDLE);
  assign busy   = ~ready;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
- Multi-cycle M-extension execution unit (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) beside the combinational RV32I execute stage.
- Execute stage raises start for OP_R instructions with funct7 = 7'b0000001.
- Core controller stalls the pipeline while busy. The result returns on a done pulse and is written to rd by the execute stage.
- Parametrised in data width, multiplier architecture and divider radix.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- MUL_ITERATIVE, 0, 0 = single product computed in FINISH; 1 = radix-2 shift-add over XLEN cycles.
- DIV_BITS_PER_CYCLE, 1, quotient bits resolved per iteration; legal values 1 or 2, and XLEN must be divisible by it.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; accepted only when ready=1
- funct3  input  3  M-extension op select (RV32M encoding)
- operand1  input  XLEN  rs1 value
- operand2  input  XLEN  rs2 value
- flush  input  1  abort current operation (trap/jump in flight)
- ready  output  1  unit idle, can accept start
- busy  output  1  operation in progress; core controller stalls
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  result; held until the next done

Behaviour:
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, all internal registers 0.
- States and transitions:
  - IDLE: on start, latch funct3, operands and sign flags; magnitudes are captured for signed ops. Go to MUL_ITER, DIV_ITER or FINISH.
  - IDLE to FINISH directly for: fast MUL (MUL_ITERATIVE=0), divisor==0, and signed overflow (dividend = most negative, divisor = -1).
  - MUL_ITER: XLEN cycles, one multiplier bit per cycle into a 2*XLEN accumulator. Counter hits 0, go to FINISH.
  - DIV_ITER: XLEN/DIV_BITS_PER_CYCLE cycles of restoring division on magnitudes. Counter hits 0, go to FINISH.
  - FINISH: apply sign correction and select the low or high half (MUL low; MULH/MULHSU/MULHU high). Register result, assert done next cycle, return to IDLE.
- ready = (state==IDLE); busy = !ready.
- done is registered and high for exactly the cycle after FINISH, when state is already IDLE. A start in that same cycle is accepted (back-to-back).
- Latency from the start-accept cycle (cycle 0) to the done cycle:
  - fast MUL: 2.
  - iterative MUL: XLEN+2.
  - DIV/REM: XLEN/DIV_BITS_PER_CYCLE + 2.
  - special cases: 2.
- Sign rules:
  - MULH: signed x signed.
  - MULHSU: signed rs1 x unsigned rs2.
  - MULHU: unsigned x unsigned.
  - Products negated when sign flags differ, in 2*XLEN width.
  - Quotient negative iff operand signs differ; remainder takes the dividend's sign.
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = dividend.
- Signed overflow: quotient = dividend (most negative); remainder = 0.
- Operations with operand2 == 0 for MUL go through the normal path; no shortcut is required.
- start while busy: ignored. The execute stage is held by the stall, so no request is lost.
- flush: in any state other than IDLE, return to IDLE next cycle with no done and result unchanged. flush in IDLE drops a coincident start. flush has priority over FINISH.
- rst mid-operation: immediate return to reset values.
- Unused funct3 values are impossible by decode. If they occur, they are treated as MUL.

Decomposition:
- Shared package (RV32M_Inst_Pkg, alongside RV32I_Inst_Pkg):
  - funct3 constants RV32M_MUL … RV32M_REMU.
  - RV32M_FUNCT7 = 7'b0000001.
  - state enum muldiv_state_t.
- Sub-module muldiv_div_step: combinational restoring step, parametrised by XLEN and DIV_BITS_PER_CYCLE, instantiated once in DIV_ITER.
- The multiplier stays inline.

Test Plan:
- MUL 7 x -3 (XLEN=32, MUL_ITERATIVE=0): done at cycle 2, result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE. Repeat with MUL_ITERATIVE=1; done at cycle 34.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Done at cycle 34 for DIV_BITS_PER_CYCLE=1 and cycle 18 for 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM with the same operands -> 0. All complete with done at cycle 2.
- flush at cycle 10 of a DIV: no done, ready=1 at cycle 11, result keeps its prior value. A new MUL started at cycle 11 completes correctly.
- Back-to-back: a MUL start in the done cycle of a DIV is accepted. Assert rst at DIV cycle 5: all outputs return to reset values asynchronously.
